// File: rtl/distance_filter_if.sv
// Sample/result bus between the ultrasonic ranger front end and the distance filter.
interface distance_filter_if;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [7:0] distance_out;
  logic       out_valid;
  logic       locked;
  logic       stale;
  logic [7:0] reject_count;

  // Producer of raw samples, consumer of filtered distance.
  modport master (
    output sample_in, sample_valid,
    input  distance_out, out_valid, locked, stale, reject_count
  );

  // The filter itself.
  modport slave (
    input  sample_in, sample_valid,
    output distance_out, out_valid, locked, stale, reject_count
  );
endinterface

// File: rtl/distance_filter.sv
// Moving-average distance filter with outlier rejection, re-acquisition and staleness timeout.
module distance_filter #(
  parameter int unsigned DEPTH_LOG2     = 2,
  parameter int unsigned MAX_JUMP       = 40,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic             clock,
  input  logic             resetn,
  distance_filter_if.slave bus
);

  localparam int unsigned N  = 1 << DEPTH_LOG2;
  localparam int unsigned SW = 8 + DEPTH_LOG2;
  localparam int unsigned PW = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int unsigned FW = DEPTH_LOG2 + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_TRACKING} state_t;

  state_t          r_state;
  logic [7:0]      r_win [N];
  logic [PW-1:0]   r_ptr;
  logic [SW-1:0]   r_sum;
  logic [FW-1:0]   r_fill;
  logic [1:0]      r_rej_run;
  logic [TW-1:0]   r_tmo;
  logic [7:0]      r_dist;
  logic            r_out_valid;
  logic            r_locked;
  logic            r_stale;
  logic [7:0]      r_rej_cnt;

  logic            w_nonzero;
  logic            w_zero_strobe;
  logic [8:0]      w_diff;
  logic [8:0]      w_abs;
  logic            w_outlier;
  logic            w_reacq;
  logic            w_accept;
  logic [7:0]      w_oldest;
  logic [SW-1:0]   w_sum_fill;
  logic [SW-1:0]   w_sum_track;
  logic [PW-1:0]   w_ptr_inc;
  logic [FW-1:0]   w_fill_inc;

  // Sample qualification, deviation test and next-sum arithmetic.
  always_comb begin
    w_nonzero     = bus.sample_valid && (bus.sample_in != 8'd0);
    w_zero_strobe = bus.sample_valid && (bus.sample_in == 8'd0);
    w_diff        = {1'b0, bus.sample_in} - {1'b0, r_dist};
    w_abs         = w_diff[8] ? (9'd0 - w_diff) : w_diff;
    w_outlier     = (r_state == S_TRACKING) && w_nonzero && (w_abs > 9'(MAX_JUMP));
    w_reacq       = w_outlier && (r_rej_run == 2'd2);
    w_accept      = w_nonzero && (!w_outlier || w_reacq);
    w_oldest      = r_win[r_ptr];
    w_sum_fill    = r_sum + SW'(bus.sample_in);
    w_sum_track   = r_sum + SW'(bus.sample_in) - SW'(w_oldest);
    w_ptr_inc     = (r_ptr == PW'(N - 1)) ? '0 : r_ptr + PW'(1);
    w_fill_inc    = r_fill + FW'(1);
  end

  // State machine, window update, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= S_EMPTY;
      r_ptr       <= '0;
      r_sum       <= '0;
      r_fill      <= '0;
      r_rej_run   <= '0;
      r_tmo       <= '0;
      r_dist      <= '0;
      r_out_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_stale     <= 1'b0;
      r_rej_cnt   <= '0;
      for (int i = 0; i < int'(N); i++) r_win[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        // Accepted samples (including a re-acquire) refresh the timeout and win over it.
        r_tmo       <= '0;
        r_stale     <= 1'b0;
        r_rej_run   <= '0;
        r_out_valid <= 1'b1;
        if (w_reacq && (r_rej_cnt != 8'hFF)) r_rej_cnt <= r_rej_cnt + 8'd1;
        if ((r_state == S_EMPTY) || w_reacq) begin
          r_win[0] <= bus.sample_in;
          r_sum    <= SW'(bus.sample_in);
          r_fill   <= FW'(1);
          r_ptr    <= PW'((N > 1) ? 1 : 0);
          r_dist   <= bus.sample_in;
          if (N == 1) begin
            r_state  <= S_TRACKING;
            r_locked <= 1'b1;
          end else begin
            r_state  <= S_FILLING;
            r_locked <= 1'b0;
          end
        end else if (r_state == S_FILLING) begin
          r_win[r_ptr] <= bus.sample_in;
          r_sum        <= w_sum_fill;
          r_fill       <= w_fill_inc;
          r_ptr        <= w_ptr_inc;
          if (w_fill_inc == FW'(N)) begin
            r_dist   <= 8'(w_sum_fill >> DEPTH_LOG2);
            r_state  <= S_TRACKING;
            r_locked <= 1'b1;
          end else begin
            r_dist   <= bus.sample_in;
          end
        end else begin
          r_win[r_ptr] <= bus.sample_in;
          r_sum        <= w_sum_track;
          r_ptr        <= w_ptr_inc;
          r_dist       <= 8'(w_sum_track >> DEPTH_LOG2);
        end
      end else begin
        if (w_outlier) begin
          if (r_rej_cnt != 8'hFF) r_rej_cnt <= r_rej_cnt + 8'd1;
          r_rej_run <= r_rej_run + 2'd1;
        end
        // No-echo strobes freeze the timeout; otherwise count up and fire once on reaching the limit.
        if (!w_zero_strobe && (r_tmo != TW'(TIMEOUT_CYCLES))) begin
          r_tmo <= r_tmo + TW'(1);
          if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            r_stale   <= 1'b1;
            r_state   <= S_EMPTY;
            r_fill    <= '0;
            r_rej_run <= '0;
            r_locked  <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.distance_out = r_dist;
  assign bus.out_valid    = r_out_valid;
  assign bus.locked       = r_locked;
  assign bus.stale        = r_stale;
  assign bus.reject_count = r_rej_cnt;

endmodule

// File: doc/distance_filter.md
DISTANCE_FILTER -- requirements
Module: distance_filter

Interface
REQ-001 Parameter DEPTH_LOG2, default 2: log2 of the averaging window length N (N=4).
REQ-002 Parameter MAX_JUMP, default 40: largest accepted deviation from distance_out while TRACKING, in cm.
REQ-003 Parameter TIMEOUT_CYCLES, default 50_000_000: clock cycles without an accepted sample before the output is declared stale.
REQ-004 clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 sample_in  in  8  raw distance sample from the ultrasonic ranger, in cm.
REQ-007 sample_valid  in  1  one-cycle strobe qualifying sample_in.
REQ-008 distance_out  out  8  filtered distance in cm, feeding the BCD display and the tone generator.
REQ-009 out_valid  out  1  one-cycle pulse each time distance_out is updated.
REQ-010 locked  out  1  high while state is TRACKING.
REQ-011 stale  out  1  high once TIMEOUT_CYCLES have elapsed with no accepted sample.
REQ-012 reject_count  out  8  saturating count of outlier samples rejected since reset.

Function
REQ-013 States SHALL be EMPTY, FILLING and TRACKING; a window of N 8-bit samples SHALL be kept with a running sum of width 8+DEPTH_LOG2.
REQ-014 A sample_valid cycle with sample_in==0 (no echo) SHALL be ignored: no state, sum, counter or timeout change.
REQ-015 EMPTY, nonzero sample: store it, sum<=sample, fill count<=1, distance_out<=sample, pulse out_valid, go to FILLING (N=1: straight to TRACKING).
REQ-016 FILLING, nonzero sample: store it, sum+=sample, distance_out<=sample, pulse out_valid; when fill count reaches N, distance_out<=(sum+sample)>>DEPTH_LOG2 instead, and go to TRACKING.
REQ-017 TRACKING, nonzero sample with |sample_in-distance_out|<=MAX_JUMP: accept it, overwrite the oldest entry, sum<=sum+sample-oldest, distance_out<=new_sum>>DEPTH_LOG2 (truncating), pulse out_valid.
REQ-018 TRACKING, |sample_in-distance_out|>MAX_JUMP: reject it, leave the window unchanged, no out_valid, reject_count+=1 (saturating at 255), consecutive-reject counter+=1.
REQ-019 The third consecutive reject SHALL re-acquire: the window is flushed and handled as an EMPTY-state sample (REQ-015): distance_out<=sample, out_valid pulses, state goes to FILLING; the consecutive-reject counter clears.
REQ-020 Any accepted sample SHALL clear the consecutive-reject counter.
REQ-021 Latency: distance_out and out_valid SHALL update on the first rising edge after the sample_valid cycle; back-to-back strobes SHALL each be processed.
REQ-022 Timeout counter SHALL clear on every accepted sample and increment otherwise, saturating at TIMEOUT_CYCLES.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES, stale SHALL be set, state SHALL return to EMPTY, fill and reject-run counters SHALL clear, and distance_out SHALL hold its last value.
REQ-024 stale SHALL clear on the edge that accepts the next nonzero sample.
REQ-025 If a sample is accepted in the same cycle the timeout fires, the sample SHALL win: the counter clears and stale stays low.
REQ-026 Rejected samples (REQ-018) SHALL NOT reset the timeout counter; the re-acquiring sample (REQ-019) SHALL.

Reset
REQ-027 With resetn low at a rising edge: state=EMPTY, distance_out=0, out_valid=0, locked=0, stale=0, reject_count=0, sum, window, fill, reject-run and timeout counters=0.
REQ-028 Reset asserted mid-operation SHALL discard all window contents; sample_valid during reset SHALL be ignored.

Verification
REQ-029 Fill: samples 20,24,28,32 -> distance_out 20,24,28 then 26; locked rises with the 4th out_valid.
REQ-030 Track: after REQ-029, sample 36 -> window 24,28,32,36, distance_out=30, out_valid pulses once.
REQ-031 Outlier: at distance_out=30, samples 200,200 -> no out_valid, reject_count=2, distance_out=30; third 200 -> distance_out=200, locked=0, state FILLING.
REQ-032 Zero/run reset: at distance_out=30, sequence 200,10,200 -> 10 accepted (|10-30|=20); reject_count=2, no re-acquire.
REQ-033 Timeout (TIMEOUT_CYCLES=100): no samples for 100 cycles -> stale=1, locked=0, distance_out held; next sample 50 -> stale=0, distance_out=50; sample 0 at any point -> no effect.
REQ-034 Reset mid-FILLING after two samples -> all outputs 0; next sample 15 -> distance_out=15, fill count restarts at 1.
